pll_reconfig_seq: RTL

- Sequencer for a four-output fractional-free PLL (50 MHz ref, outputs 100/10/30/80 MHz at default) plus its Altera reconfiguration Avalon-MM management port.
- On request, writes new N, M and C-counter values and issues the start command.
- Supervises relock, and drives a downstream domain reset that is held until the PLL lock is stable.
- Sits between the core's video/timing mode logic and the PLL reconfig IP, in the management clock domain.

---
 rtl/pll_reconfig_seq_if.sv | 40 ++++
 rtl/pll_reconfig_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_seq_if
// Brief    : Request, Avalon-MM management and lock/reset bundle for the
//            PLL reconfiguration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pll_reconfig_seq_if #(
    parameter int NUM_C = 4
);
    logic                 cfg_start;
    logic [17:0]          cfg_n;
    logic [17:0]          cfg_m;
    logic [NUM_C*18-1:0]  cfg_c;
    logic                 cfg_busy;
    logic                 cfg_done;
    logic                 cfg_err;
    logic [5:0]           mgmt_address;
    logic [31:0]          mgmt_writedata;
    logic                 mgmt_write;
    logic                 mgmt_read;
    logic                 mgmt_waitrequest;
    logic                 pll_locked;
    logic                 dom_rst;

    // The sequencer is the Avalon master; the slave side is the mode logic,
    // reconfig IP and PLL seen together.
    modport master (
        input  cfg_start, cfg_n, cfg_m, cfg_c, mgmt_waitrequest, pll_locked,
        output cfg_busy, cfg_done, cfg_err, mgmt_address, mgmt_writedata,
               mgmt_write, mgmt_read, dom_rst
    );

    modport slave (
        output cfg_start, cfg_n, cfg_m, cfg_c, mgmt_waitrequest, pll_locked,
        input  cfg_busy, cfg_done, cfg_err, mgmt_address, mgmt_writedata,
               mgmt_write, mgmt_read, dom_rst
    );
endinterface
`default_nettype wire

// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_seq
// Brief    : Writes N/M/C counters to the PLL reconfig IP, starts it, and
//            holds the downstream domain reset until lock is stable.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_seq #(
    parameter int NUM_C        = 4,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    pll_reconfig_seq_if.master bus
);

    localparam int          c_num_wr   = NUM_C + 4;
    localparam int          c_stab_w   = $clog2(LOCK_STABLE + 1);
    localparam int          c_to_w     = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [4:0]  c_last     = 5'(c_num_wr - 1);
    localparam logic [5:0]  c_addr_mode  = 6'd0;
    localparam logic [5:0]  c_addr_start = 6'd2;
    localparam logic [5:0]  c_addr_n     = 6'd3;
    localparam logic [5:0]  c_addr_m     = 6'd4;
    localparam logic [5:0]  c_addr_c     = 6'd5;
    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(LOCK_STABLE - 1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_GAP      = 3'd3,
        ST_LOCKWAIT = 3'd4
    } state_t;

    state_t                r_state;
    logic [4:0]            r_step;
    logic [c_stab_w-1:0]   r_stab;
    logic [c_to_w-1:0]     r_to;
    logic                  r_reconf;
    logic [17:0]           r_n;
    logic [17:0]           r_m;
    logic [NUM_C*18-1:0]   r_c;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [5:0]            r_addr;
    logic [31:0]           r_data;
    logic                  r_write;
    logic                  r_dom_rst;
    logic [5:0]            w_addr;
    logic [31:0]           w_data;

    // Address/data of write r_step, built from the captured request.
    always_comb begin
        w_addr = c_addr_mode;
        w_data = '0;
        if (r_step == 5'd1) begin
            w_addr = c_addr_n;
            w_data = {14'b0, r_n};
        end else if (r_step == 5'd2) begin
            w_addr = c_addr_m;
            w_data = {14'b0, r_m};
        end else if (r_step == c_last) begin
            w_addr = c_addr_start;
            w_data = 32'd1;
        end
        for (int i = 0; i < NUM_C; i++) begin
            if (r_step == 5'(i + 3)) begin
                w_addr = c_addr_c;
                w_data = {9'b0, 5'(i), r_c[i*18 +: 18]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_step    <= '0;
            r_stab    <= '0;
            r_to      <= '0;
            r_reconf  <= 1'b0;
            r_n       <= '0;
            r_m       <= '0;
            r_c       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_write   <= 1'b0;
            r_dom_rst <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_dom_rst <= 1'b1;
                    r_stab    <= '0;
                    r_to      <= '0;
                    r_reconf  <= 1'b0;
                    r_state   <= ST_LOCKWAIT;
                end
                ST_IDLE: begin
                    if (bus.cfg_start) begin
                        r_n       <= bus.cfg_n;
                        r_m       <= bus.cfg_m;
                        r_c       <= bus.cfg_c;
                        r_busy    <= 1'b1;
                        r_dom_rst <= 1'b1;
                        r_step    <= '0;
                        r_write   <= 1'b1;
                        r_addr    <= c_addr_mode;
                        r_data    <= '0;
                        r_state   <= ST_WRITE;
                    end else if (!bus.pll_locked) begin
                        r_dom_rst <= 1'b1;
                        r_stab    <= '0;
                        r_to      <= '0;
                        r_reconf  <= 1'b0;
                        r_state   <= ST_LOCKWAIT;
                    end
                end
                ST_WRITE: begin
                    // r_write is always high here, so no waitrequest means acceptance.
                    if (!bus.mgmt_waitrequest) begin
                        r_write <= 1'b0;
                        if (r_step == c_last) begin
                            r_stab   <= '0;
                            r_to     <= '0;
                            r_reconf <= 1'b1;
                            r_state  <= ST_LOCKWAIT;
                        end else begin
                            r_step  <= r_step + 5'd1;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    r_write <= 1'b1;
                    r_addr  <= w_addr;
                    r_data  <= w_data;
                    r_state <= ST_WRITE;
                end
                ST_LOCKWAIT: begin
                    if (bus.pll_locked && (r_stab == c_stab_last)) begin
                        r_dom_rst <= 1'b0;
                        r_done    <= r_reconf;
                        r_busy    <= 1'b0;
                        r_reconf  <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (r_to == c_to_last) begin
                        // Only the first timeout after a request is reported.
                        r_err    <= r_reconf;
                        r_busy   <= 1'b0;
                        r_reconf <= 1'b0;
                        r_stab   <= '0;
                        r_to     <= '0;
                    end else begin
                        r_to   <= r_to + c_to_w'(1);
                        r_stab <= bus.pll_locked ? r_stab + c_stab_w'(1) : '0;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.cfg_busy       = r_busy;
    assign bus.cfg_done       = r_done;
    assign bus.cfg_err        = r_err;
    assign bus.mgmt_address   = r_addr;
    assign bus.mgmt_writedata = r_data;
    assign bus.mgmt_write     = r_write;
    assign bus.mgmt_read      = 1'b0;
    assign bus.dom_rst        = r_dom_rst;

endmodule
`default_nettype wire
